// File: rtl/round_robin_arbiter_n_if.sv
// Request/grant bundle for round_robin_arbiter_n.
// master = requester side, slave = arbiter side.
interface round_robin_arbiter_n_if #(
   parameter int N = 4
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  requests;
   logic [N-1:0]  grants;
   logic          grant_valid;
   logic [IW-1:0] grant_index;

   modport master (
      output requests,
      input  grants,
      input  grant_valid,
      input  grant_index
   );

   modport slave (
      input  requests,
      output grants,
      output grant_valid,
      output grant_index
   );
endinterface

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with zero-cycle grant from requests and a rotating priority pointer.
// Optional quantum hold (define ARB_QUANTUM_EN) keeps the last holder for up to QUANTUM consecutive cycles.
//
// state          | meaning
// ptr_q          | index with highest priority for the next search
// holder_q       | last granted index (quantum build only)
// holder_valid_q | holder_q was granted in the previous cycle (quantum build only)
// count_q        | consecutive grant cycles of holder_q, 1..QUANTUM (quantum build only)
module round_robin_arbiter_n #(
   parameter int N       = 4,
   parameter int QUANTUM = 4
) (
   input logic                    clk,
   input logic                    rst,
   round_robin_arbiter_n_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(QUANTUM + 1);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic          gnt_found;
   logic [IW-1:0] gnt_idx;
   logic [IW:0]   scan;

`ifdef ARB_QUANTUM_EN
   logic [IW-1:0] holder_q;
   logic [IW-1:0] holder_d;
   logic          holder_valid_q;
   logic          holder_valid_d;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q          <= '0;
`ifdef ARB_QUANTUM_EN
         holder_q       <= '0;
         holder_valid_q <= 1'b0;
         count_q        <= '0;
`endif
      end else begin
         ptr_q          <= ptr_d;
`ifdef ARB_QUANTUM_EN
         holder_q       <= holder_d;
         holder_valid_q <= holder_valid_d;
         count_q        <= count_d;
`endif
      end
   end

   // Count saturates at QUANTUM so a lone holder re-won by the normal search
   // does not regain hold priority over newly arriving requesters.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_found) begin
         ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
      end
`ifdef ARB_QUANTUM_EN
      holder_d       = holder_q;
      holder_valid_d = holder_valid_q;
      count_d        = count_q;
      if (gnt_found) begin
         if (holder_valid_q && (holder_q == gnt_idx)) begin
            count_d = (count_q < CW'(QUANTUM)) ? count_q + CW'(1) : count_q;
         end else begin
            count_d = CW'(1);
         end
         holder_d       = gnt_idx;
         holder_valid_d = 1'b1;
      end else begin
         holder_valid_d = 1'b0;
         count_d        = '0;
      end
`endif
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int i = 0; i < N; i++) begin
         scan = {1'b0, ptr_q} + (IW + 1)'(i);
         if (scan >= (IW + 1)'(N)) begin
            scan = scan - (IW + 1)'(N);
         end
         if (!gnt_found && bus.requests[scan[IW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan[IW-1:0];
         end
      end
`ifdef ARB_QUANTUM_EN
      if (holder_valid_q && bus.requests[holder_q] && (count_q < CW'(QUANTUM))) begin
         gnt_found = 1'b1;
         gnt_idx   = holder_q;
      end
`endif
      if (rst) begin
         gnt_found = 1'b0;
         gnt_idx   = '0;
      end
   end

   assign bus.grants      = gnt_found ? (N'(1) << gnt_idx) : '0;
   assign bus.grant_valid = gnt_found;
   assign bus.grant_index = gnt_idx;

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n (N=4, QUANTUM=3): directed vector table, hand sequences,
// then random requests against a rule-level reference model. Build with or without ARB_QUANTUM_EN.
module tb_round_robin_arbiter_n;
   localparam int N       = 4;
   localparam int QUANTUM = 3;
`ifdef ARB_QUANTUM_EN
   localparam bit QEN     = 1'b1;
`else
   localparam bit QEN     = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   round_robin_arbiter_n_if #(.N(N)) bus ();

   round_robin_arbiter_n #(.N(N), .QUANTUM(QUANTUM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] req, input logic [3:0] gnt);
      vec_t v;
      v.rst = r;
      v.req = req;
      v.gnt = gnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] g);
      int r = 0;
      for (int k = 0; k < N; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic apply(input logic r, input logic [3:0] req);
      @(posedge clk);
      #1;
      rst          = r;
      bus.requests = req;
      @(negedge clk);
   endtask

   task automatic check_outputs(input string name, input logic [3:0] exp_gnt);
      check({name, "_grants"}, 32'(bus.grants), 32'(exp_gnt));
      check({name, "_valid"}, 32'(bus.grant_valid), 32'(|exp_gnt));
      check({name, "_index"}, 32'(bus.grant_index), 32'(idx_of(exp_gnt)));
   endtask

   // reference model state: pointer, holder, consecutive count
   int m_ptr, m_h, m_c;
   bit m_hv;
   int waitc[N];

   function automatic int model_pick(input logic r, input logic [3:0] req);
      int g = -1;
      if (r) return -1;
      if (QEN && m_hv && req[m_h[1:0]] && (m_c < QUANTUM)) return m_h;
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (g < 0 && req[j[1:0]]) g = j;
      end
      return g;
   endfunction

   task automatic model_step(input logic r, input int g);
      if (r) begin
         m_ptr = 0; m_h = 0; m_hv = 1'b0; m_c = 0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         if (m_hv && m_h == g) m_c = (m_c < QUANTUM) ? m_c + 1 : QUANTUM;
         else m_c = 1;
         m_h  = g;
         m_hv = 1'b1;
      end else begin
         m_hv = 1'b0;
         m_c  = 0;
      end
   endtask

   initial begin
      logic [3:0] req;
      logic [3:0] hold_mask;
      logic [3:0] exp_gnt;
      logic       r;
      int         g;
      int         bound;

      bus.requests = '0;

      add(1, 4'b1111, 4'b0000);
`ifdef ARB_QUANTUM_EN
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0001);
      add(0, 4'b1111, 4'b0010); add(0, 4'b1111, 4'b0010); add(0, 4'b1111, 4'b0010);
      add(0, 4'b1111, 4'b0100);
      add(1, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0001);
      add(0, 4'b1110, 4'b0010);
      add(1, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0001);
      add(1, 4'b1111, 4'b0000); add(1, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0001);
`else
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0010);
      add(0, 4'b1111, 4'b0100); add(0, 4'b1111, 4'b1000);
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0010);
      add(0, 4'b1111, 4'b0100); add(0, 4'b1111, 4'b1000);
      add(1, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0001);
      add(0, 4'b0000, 4'b0000); add(0, 4'b0000, 4'b0000); add(0, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0010);
      add(1, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0010); add(0, 4'b1111, 4'b0100);
      add(0, 4'b0011, 4'b0001);
      add(1, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0001); add(0, 4'b1111, 4'b0010);
      add(1, 4'b1111, 4'b0000); add(1, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0001);
`endif

      for (int k = 0; k < vecs.size(); k++) begin
         apply(vecs[k].rst, vecs[k].req);
         check_outputs($sformatf("vec%0d", k), vecs[k].gnt);
      end

      // lone continuous requester, then wrap from ptr=3 to index 0
      apply(1, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         apply(0, 4'b0100);
         check_outputs("lone_req", 4'b0100);
      end
      apply(0, 4'b0011);
      check_outputs("wrap", 4'b0001);
      apply(0, 4'b0000);
      check_outputs("idle", 4'b0000);

      // random phase against the reference model
      apply(1, 4'b0000);
      model_step(1'b1, -1);
      foreach (waitc[i]) waitc[i] = 0;
      bound     = QEN ? N * QUANTUM : N;
      hold_mask = '0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (cyc % 40 == 0) hold_mask = 4'($urandom_range(0, 15));
         r   = ($urandom_range(0, 99) == 0);
         req = 4'($urandom) & 4'($urandom_range(0, 15)) | hold_mask;
         apply(r, req);
         g       = model_pick(r, req);
         exp_gnt = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         check_outputs("rand", exp_gnt);
         check("rand_onehot_subset",
               32'($onehot0(bus.grants) && ((bus.grants & ~req) == 4'b0000)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (r || !req[i] || bus.grants[i]) waitc[i] = 0;
            else waitc[i]++;
         end
         check("rand_fairness", 32'(waitc[0] < bound && waitc[1] < bound &&
                                    waitc[2] < bound && waitc[3] < bound), 32'd1);
         model_step(r, g);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/round_robin_arbiter_n.md
ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter QUANTUM, default 4: max consecutive grant cycles per holder; legal range 1..256; used only when ARB_QUANTUM_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 requests  input  N  bit i high = requester i asks for grant this cycle.
REQ-006 grants  output  N  one-hot grant (or all-zero); combinational from requests and internal state.
REQ-007 grant_valid  output  1  OR of grants.
REQ-008 grant_index  output  $clog2(N)  binary index of the set grants bit; 0 when grant_valid is 0.

Function
REQ-009 The block SHALL hold a priority pointer ptr in 0..N-1; requester ptr has highest priority, then ptr+1, ... wrapping modulo N.
REQ-010 grants SHALL select the first set requests bit in that search order, in the same cycle requests is applied (zero-cycle latency).
REQ-011 grants SHALL never have more than one bit set, and grants[i] SHALL be 1 only if requests[i] is 1.
REQ-012 At each rising edge with grant_valid=1 to index g, ptr SHALL become (g+1) mod N; with grant_valid=0, ptr SHALL be unchanged.
REQ-013 requests=0 SHALL give grants=0, grant_valid=0, grant_index=0.
REQ-014 Wrap-around: with ptr=N-1 and requests[N-1]=0, the search SHALL continue at index 0.
REQ-015 A single continuously asserted requester SHALL be granted every cycle.
REQ-016 Fairness: any requester held high SHALL be granted within N cycles (within N*QUANTUM cycles when ARB_QUANTUM_EN is defined).

Reset
REQ-017 While rst is 1, grants, grant_valid and grant_index SHALL be 0 regardless of requests.
REQ-018 A rising edge with rst=1 SHALL set ptr to 0, clear holder state and clear the quantum counter.
REQ-019 rst asserted mid-operation SHALL override a current grant or hold in the same cycle; the first cycle after rst deasserts SHALL arbitrate from ptr=0.

Configuration
REQ-020 Macro ARB_QUANTUM_EN SHALL enable quantum hold; without it, priority rotates after every granted cycle (REQ-012 only).
REQ-021 With ARB_QUANTUM_EN, the block SHALL track holder h (last granted index) and count c (consecutive cycles h was granted, 1..QUANTUM).
REQ-022 With ARB_QUANTUM_EN, if h is valid, requests[h]=1 and c<QUANTUM, grants SHALL select h regardless of ptr; otherwise normal search from ptr applies.
REQ-023 With ARB_QUANTUM_EN, a grant to h again SHALL increment c; a grant to a new index SHALL set c=1; grant_valid=0 SHALL invalidate h.
REQ-024 With ARB_QUANTUM_EN and QUANTUM=1, behaviour SHALL be cycle-identical to the macro-off build.

Verification (N=4, QUANTUM=3)
REQ-025 Macro off, after reset requests=4'b1111 for 8 cycles -> grants 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-026 Macro off, requests 1111 one cycle (grant 0001), then 0000 three cycles -> grants 0000, grant_valid 0; then 1111 -> grants 0010 (ptr kept at 1).
REQ-027 Macro off, 1111 for 3 cycles (last grant 0100, ptr=3), then 0011 -> grants 0001, grant_index 0 (wrap).
REQ-028 Macro on, requests 1111 for 7 cycles -> 0001,0001,0001,0010,0010,0010,0100; early drop: 0001 granted 2 cycles, then requests 1110 -> grants 0010.
REQ-029 Either build, requests 1111 for 2 cycles, rst=1 for 2 cycles -> grants 0000 during rst; after release with 1111 -> grants 0001.
REQ-030 Either build, random requests for 1000 cycles -> grants always one-hot-or-zero, subset of requests, and REQ-016 bound holds.
